ac_stream_bridge: RTL and testbench

Sample-rate buffering bridge between the audio codec core's tick-based ADC/DAC sample interface and two valid/ready streaming interfaces. It sits beside the codec core on the audio clock. On each sample tick it:
- captures the stereo ADC pair into an ADC FIFO that a downstream processing block drains;
- presents the next stereo DAC pair, which an upstream block has buffered into a DAC FIFO.

Overflow and underflow are counted as sticky flags and never stall the codec.

---
 rtl/ac_stream_bridge.sv | 178 +++++++++++++++++
 tb/tb_ac_stream_bridge.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_stream_bridge.sv
// Sample-rate buffering bridge between the codec core's tick-based sample interface and
// two valid/ready streams: ADC pairs are queued for a drain, DAC pairs are replayed per tick.
module ac_stream_bridge #(
  parameter int unsigned DATA_WDT = 24,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned LVL_WDT  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [DATA_WDT-1:0]   adcDataL,
  input  logic [DATA_WDT-1:0]   adcDataR,
  output logic [DATA_WDT-1:0]   dacDataL,
  output logic [DATA_WDT-1:0]   dacDataR,
  output logic                  adcValid,
  input  logic                  adcReady,
  output logic [2*DATA_WDT-1:0] adcData,
  input  logic                  dacValid,
  output logic                  dacReady,
  input  logic [2*DATA_WDT-1:0] dacSinkData,
  output logic [LVL_WDT-1:0]    adcLevel,
  output logic [LVL_WDT-1:0]    dacLevel,
  output logic                  adcOvf,
  output logic                  dacUnd,
  input  logic                  clrFlags
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned PairW = 2 * DATA_WDT;
  localparam logic [LVL_WDT-1:0] LvlFull = LVL_WDT'(DEPTH);

  // ---------------------------------------------------------------------------
  // ADC FIFO
  // ---------------------------------------------------------------------------
  logic [PairW-1:0]   adc_mem [DEPTH];
  logic [PtrW-1:0]    adc_wr_q, adc_wr_d;
  logic [PtrW-1:0]    adc_rd_q, adc_rd_d;
  logic [LVL_WDT-1:0] adc_lvl_q, adc_lvl_d;
  logic               adc_full, adc_push, adc_pop, adc_drop;

  always_comb begin
    adc_full = (adc_lvl_q == LvlFull);
    adc_pop  = adcValid & adcReady;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    adc_push = tick & (~adc_full | adc_pop);
    adc_drop = tick & adc_full & ~adc_pop;
    adc_wr_d = adc_wr_q + PtrW'(adc_push);
    adc_rd_d = adc_rd_q + PtrW'(adc_pop);
    adc_lvl_d = adc_lvl_q;
    case ({adc_push, adc_pop})
      2'b10:   adc_lvl_d = adc_lvl_q + 1'b1;
      2'b01:   adc_lvl_d = adc_lvl_q - 1'b1;
      default: adc_lvl_d = adc_lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (adc_push) begin
      adc_mem[adc_wr_q] <= {adcDataL, adcDataR};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adc_wr_q  <= '0;
      adc_rd_q  <= '0;
      adc_lvl_q <= '0;
    end else begin
      adc_wr_q  <= adc_wr_d;
      adc_rd_q  <= adc_rd_d;
      adc_lvl_q <= adc_lvl_d;
    end
  end

  assign adcValid = (adc_lvl_q != '0);
  assign adcData  = adc_mem[adc_rd_q];
  assign adcLevel = adc_lvl_q;

  // ---------------------------------------------------------------------------
  // DAC FIFO and output registers
  // ---------------------------------------------------------------------------
  logic [PairW-1:0]    dac_mem [DEPTH];
  logic [PtrW-1:0]     dac_wr_q, dac_wr_d;
  logic [PtrW-1:0]     dac_rd_q, dac_rd_d;
  logic [LVL_WDT-1:0]  dac_lvl_q, dac_lvl_d;
  logic [DATA_WDT-1:0] dac_l_q, dac_l_d;
  logic [DATA_WDT-1:0] dac_r_q, dac_r_d;
  logic [PairW-1:0]    dac_head;
  logic                refill_q;
  logic                dac_empty, dac_push, dac_pop, dac_und;

  always_comb begin
    dac_head  = dac_mem[dac_rd_q];
    dac_empty = (dac_lvl_q == '0);
    dac_push  = dacValid & dacReady;
    dac_pop   = refill_q & ~dac_empty;
    dac_und   = refill_q & dac_empty;
    dac_wr_d  = dac_wr_q + PtrW'(dac_push);
    dac_rd_d  = dac_rd_q + PtrW'(dac_pop);
    dac_lvl_d = dac_lvl_q;
    case ({dac_push, dac_pop})
      2'b10:   dac_lvl_d = dac_lvl_q + 1'b1;
      2'b01:   dac_lvl_d = dac_lvl_q - 1'b1;
      default: dac_lvl_d = dac_lvl_q;
    endcase
    // Outputs only move in the refill cycle; an empty FIFO plays silence.
    dac_l_d = dac_l_q;
    dac_r_d = dac_r_q;
    if (refill_q) begin
      dac_l_d = dac_pop ? dac_head[PairW-1:DATA_WDT] : '0;
      dac_r_d = dac_pop ? dac_head[DATA_WDT-1:0]     : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (dac_push) begin
      dac_mem[dac_wr_q] <= dacSinkData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dac_wr_q  <= '0;
      dac_rd_q  <= '0;
      dac_lvl_q <= '0;
      dac_l_q   <= '0;
      dac_r_q   <= '0;
      refill_q  <= 1'b0;
    end else begin
      dac_wr_q  <= dac_wr_d;
      dac_rd_q  <= dac_rd_d;
      dac_lvl_q <= dac_lvl_d;
      dac_l_q   <= dac_l_d;
      dac_r_q   <= dac_r_d;
      refill_q  <= tick;
    end
  end

  assign dacReady = (dac_lvl_q != LvlFull);
  assign dacLevel = dac_lvl_q;
  assign dacDataL = dac_l_q;
  assign dacDataR = dac_r_q;

  // ---------------------------------------------------------------------------
  // Sticky flags; a set event beats a coincident clear
  // ---------------------------------------------------------------------------
  logic ovf_q, ovf_d;
  logic und_q, und_d;

  always_comb begin
    ovf_d = ovf_q;
    und_d = und_q;
    if (clrFlags) begin
      ovf_d = 1'b0;
      und_d = 1'b0;
    end
    if (adc_drop) begin
      ovf_d = 1'b1;
    end
    if (dac_und) begin
      und_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      und_q <= und_d;
    end
  end

  assign adcOvf = ovf_q;
  assign dacUnd = und_q;

endmodule

// File: tb/tb_ac_stream_bridge.sv
// Scoreboard bench for ac_stream_bridge: directed scenarios followed by randomized traffic,
// checked against queue-based models of the ADC and DAC buffering rules.
module tb_ac_stream_bridge;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk, reset, tick;
  logic [DW-1:0] adcDataL, adcDataR, dacDataL, dacDataR;
  logic          adcValid, adcReady, dacValid, dacReady;
  logic [2*DW-1:0] adcData, dacSinkData;
  logic [LW-1:0] adcLevel, dacLevel;
  logic          adcOvf, dacUnd, clrFlags;

  ac_stream_bridge #(.DATA_WDT(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .adcDataL(adcDataL), .adcDataR(adcDataR),
    .dacDataL(dacDataL), .dacDataR(dacDataR),
    .adcValid(adcValid), .adcReady(adcReady), .adcData(adcData),
    .dacValid(dacValid), .dacReady(dacReady), .dacSinkData(dacSinkData),
    .adcLevel(adcLevel), .dacLevel(dacLevel),
    .adcOvf(adcOvf), .dacUnd(dacUnd), .clrFlags(clrFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dac_accepts = 0;

  // Scoreboard state
  logic [2*DW-1:0] exp_adc[$];
  logic [2*DW-1:0] dac_q[$];
  logic            adc_push_now = 1'b0;
  logic            adc_drop_now = 1'b0;
  logic            ovf_m = 1'b0, und_m = 1'b0, refill_m = 1'b0;
  logic [DW-1:0]   out_l_m = '0, out_r_m = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*DW-1:0] pair(input int n);
    logic [DW-1:0] a, b;
    a = DW'(n);
    b = -a;
    return {a, b};
  endfunction

  // One stimulus cycle; ADC expectations enter the scoreboard as the tick is issued.
  task automatic drive(input logic tk, input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input logic ardy, input logic dval, input logic [2*DW-1:0] dd,
                       input logic clr);
    int  sz;
    logic pop;
    @(posedge clk);
    #1;
    tick = tk; adcDataL = l; adcDataR = r; adcReady = ardy;
    dacValid = dval; dacSinkData = dd; clrFlags = clr;
    adc_push_now = 1'b0;
    adc_drop_now = 1'b0;
    if (tk && reset) begin
      sz  = exp_adc.size();
      pop = (sz != 0) && ardy;
      if (sz == int'(DEPTH) && !pop) adc_drop_now = 1'b1;
      else begin
        exp_adc.push_back({l, r});
        adc_push_now = 1'b1;
      end
    end
    if (dval && dacReady) dac_accepts++;
  endtask

  task automatic idle(input int n, input logic ardy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, ardy, 1'b0, '0, 1'b0);
  endtask

  // Monitor: compares DUT outputs with the model each cycle, then advances the model.
  always @(negedge clk) begin : monitor
    int lvl;
    int dsz;
    logic [2*DW-1:0] e;
    logic rdy_m;
    logic und_set;
    if (!reset) begin
      exp_adc.delete();
      dac_q.delete();
      ovf_m = 1'b0; und_m = 1'b0; refill_m = 1'b0;
      out_l_m = '0; out_r_m = '0;
    end else begin
      lvl = exp_adc.size() - (adc_push_now ? 1 : 0);
      chk("adc_level", 64'(adcLevel), 64'(lvl));
      chk("adc_valid", 64'(adcValid), 64'(lvl != 0));
      if (lvl != 0 && adcReady) begin
        e = exp_adc.pop_front();
        chk("adc_data", 64'(adcData), 64'(e));
      end
      chk("adc_ovf", 64'(adcOvf), 64'(ovf_m));
      ovf_m = adc_drop_now ? 1'b1 : (clrFlags ? 1'b0 : ovf_m);

      dsz = dac_q.size();
      rdy_m = (dsz != int'(DEPTH));
      chk("dac_level", 64'(dacLevel), 64'(dsz));
      chk("dac_ready", 64'(dacReady), 64'(rdy_m));
      chk("dac_l", 64'(dacDataL), 64'(out_l_m));
      chk("dac_r", 64'(dacDataR), 64'(out_r_m));
      chk("dac_und", 64'(dacUnd), 64'(und_m));
      und_set = 1'b0;
      if (refill_m) begin
        if (dsz != 0) begin
          e = dac_q.pop_front();
          out_l_m = e[2*DW-1:DW];
          out_r_m = e[DW-1:0];
        end else begin
          out_l_m = '0; out_r_m = '0;
          und_set = 1'b1;
        end
      end
      if (dacValid && rdy_m) dac_q.push_back(dacSinkData);
      und_m = und_set ? 1'b1 : (clrFlags ? 1'b0 : und_m);
      refill_m = tick;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_adc_valid"}, 64'(adcValid), 64'(0));
    chk({tag, "_adc_level"}, 64'(adcLevel), 64'(0));
    chk({tag, "_dac_level"}, 64'(dacLevel), 64'(0));
    chk({tag, "_dac_l"},     64'(dacDataL), 64'(0));
    chk({tag, "_dac_r"},     64'(dacDataR), 64'(0));
    chk({tag, "_dac_ready"}, 64'(dacReady), 64'(1));
    chk({tag, "_ovf"},       64'(adcOvf),   64'(0));
    chk({tag, "_und"},       64'(dacUnd),   64'(0));
  endtask

  initial begin
    int phase_rdy;
    reset = 1'b0; tick = 1'b0; adcDataL = '0; adcDataR = '0; adcReady = 1'b0;
    dacValid = 1'b0; dacSinkData = '0; clrFlags = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b1;

    // ADC basic
    drive(1'b1, 24'h123456, 24'hFEDCBA, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("basic_valid", 64'(adcValid), 64'(1));
    chk("basic_data", 64'(adcData), 64'h123456FEDCBA);
    drive(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("basic_valid_drop", 64'(adcValid), 64'(0));

    // ADC overflow, then drain and clear
    for (int n = 1; n <= 9; n++) drive(1'b1, DW'(n), -DW'(n), 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("ovf_level", 64'(adcLevel), 64'(8));
    chk("ovf_flag", 64'(adcOvf), 64'(1));
    idle(10, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("ovf_cleared", 64'(adcOvf), 64'(0));

    // ADC full plus simultaneous pop
    for (int n = 1; n <= 8; n++) drive(1'b1, DW'(16 + n), '0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 24'h0000AA, 24'h0000BB, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("fullpop_level", 64'(adcLevel), 64'(8));
    chk("fullpop_ovf", 64'(adcOvf), 64'(0));
    idle(10, 1'b1);

    // DAC flow with final underflow
    for (int n = 1; n <= 3; n++) drive(1'b0, '0, '0, 1'b0, 1'b1, pair(n), 1'b0);
    for (int n = 1; n <= 4; n++) begin
      drive(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      idle(2, 1'b0);
      chk("flow_l", 64'(dacDataL), 64'(pair(n < 4 ? n : 0) >> DW));
      chk("flow_r", 64'(dacDataR), 64'(pair(n < 4 ? n : 0) & {DW{1'b1}}));
    end
    chk("flow_und", 64'(dacUnd), 64'(1));
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);

    // DAC backpressure
    dac_accepts = 0;
    for (int i = 0; i < 10; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, pair(32 + i), 1'b0);
    chk("bp_ready_low", 64'(dacReady), 64'(0));
    drive(1'b1, '0, '0, 1'b0, 1'b1, pair(50), 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, pair(51), 1'b0);
    chk("bp_ready_t1", 64'(dacReady), 64'(0));
    drive(1'b0, '0, '0, 1'b0, 1'b1, pair(52), 1'b0);
    chk("bp_ready_t2", 64'(dacReady), 64'(1));
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, pair(60 + i), 1'b0);
    chk("bp_accepts", 64'(dac_accepts), 64'(9));
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      idle(1, 1'b0);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Async reset mid-operation, with a refill pending
    for (int n = 0; n < 4; n++) drive(1'b1, DW'(n), DW'(n), 1'b0, 1'b1, pair(70 + n), 1'b0);
    drive(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_vals("async");
    idle(2, 1'b0);
    reset = 1'b1;
    idle(2, 1'b0);
    chk("post_rst_dac_level", 64'(dacLevel), 64'(0));
    chk("post_rst_dac_l", 64'(dacDataL), 64'(0));
    chk("post_rst_und", 64'(dacUnd), 64'(0));
    drive(1'b0, '0, '0, 1'b0, 1'b1, pair(90), 1'b0);
    drive(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(2, 1'b0);
    chk("post_rst_refill_l", 64'(dacDataL), 64'(pair(90) >> DW));

    // Randomized traffic with shifting ready bias
    phase_rdy = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) phase_rdy = $urandom_range(0, 4);
      drive(($urandom_range(0, 3) == 0) || ($urandom_range(0, 40) == 0),
            DW'($urandom), DW'($urandom),
            $urandom_range(0, 3) < phase_rdy,
            $urandom_range(0, 4) < ((c / 150) % 5),
            {DW'($urandom), DW'($urandom)},
            $urandom_range(0, 63) == 0);
    end
    idle(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
